uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 172 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte-level frame parser for a UART receiver: SYNC, LEN, ADDR, payload, XOR checksum.
// A verified payload is buffered and replayed on a valid/ready stream.
module uart_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 20000,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ok,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frm_addr,
    output logic [4:0] frm_len,
    output logic       frm_ok,
    output logic [2:0] err,
    output logic       busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_SEND
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rx_ok_d;
    logic          strobe;
    logic [TW-1:0] tcnt;
    logic          timing;
    logic          tout;
    logic [4:0]    idx;
    logic [4:0]    rd_idx;
    logic [7:0]    xor_acc;
    logic [7:0]    buf_mem [MAX_LEN];
    logic          len_bad;
    logic          chk_good;
    logic          chk_bad;
    logic          drop;
    logic          xfer;

    assign strobe = rx_ok & ~rx_ok_d;
    assign timing = (state == S_LEN) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CHK);
    // A strobe in the expiry cycle counts as activity, so it wins over the timeout.
    assign tout   = timing && !strobe && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign busy   = (state != S_HUNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_bad   = 1'b0;
        chk_good  = 1'b0;
        chk_bad   = 1'b0;
        drop      = 1'b0;
        out_valid = (state == S_SEND) && (frm_len != 5'd0);
        out_last  = out_valid && (rd_idx == frm_len - 5'd1);
        xfer      = out_valid && out_ready;
        out_data  = out_valid ? buf_mem[rd_idx[AW-1:0]] : 8'h00;
        case (state)
            S_HUNT: begin
                if (strobe && rx_data == SYNC_BYTE) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (strobe) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        len_bad   = 1'b1;
                        state_nxt = S_HUNT;
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (strobe) state_nxt = (frm_len == 5'd0) ? S_CHK : S_DATA;
            end
            S_DATA: begin
                if (strobe && idx == frm_len - 5'd1) state_nxt = S_CHK;
            end
            S_CHK: begin
                if (strobe) begin
                    if (rx_data == xor_acc) begin
                        chk_good  = 1'b1;
                        state_nxt = S_SEND;
                    end else begin
                        chk_bad   = 1'b1;
                        state_nxt = S_HUNT;
                    end
                end
            end
            S_SEND: begin
                drop = strobe;
                if (frm_len == 5'd0 || (xfer && out_last)) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
        endcase
        if (tout) state_nxt = S_HUNT;
    end

    // Control and frame-header registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ok_d  <= 1'b1;
            tcnt     <= '0;
            idx      <= 5'd0;
            rd_idx   <= 5'd0;
            xor_acc  <= 8'h00;
            frm_addr <= 8'h00;
            frm_len  <= 5'd0;
            frm_ok   <= 1'b0;
            err      <= 3'b000;
        end else begin
            rx_ok_d <= rx_ok;
            frm_ok  <= chk_good;
            err     <= {tout | drop, len_bad, chk_bad};

            if (strobe || !timing || tout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (strobe) begin
                case (state)
                    S_LEN: begin
                        if (!len_bad) frm_len <= rx_data[4:0];
                        xor_acc <= rx_data;
                    end
                    S_ADDR: begin
                        frm_addr <= rx_data;
                        xor_acc  <= xor_acc ^ rx_data;
                        idx      <= 5'd0;
                    end
                    S_DATA: begin
                        xor_acc <= xor_acc ^ rx_data;
                        idx     <= idx + 5'd1;
                    end
                    default: ;
                endcase
            end

            if (state != S_SEND) begin
                rd_idx <= 5'd0;
            end else if (xfer) begin
                rd_idx <= rd_idx + 5'd1;
            end
        end
    end

    // Payload buffer: data path only, contents need no reset
    always_ff @(posedge clk) begin
        if (state == S_DATA && strobe) buf_mem[idx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length error, timeout,
// back-pressure with overrun, and reset in mid-frame.
module tb_uart_frame_parser;

    localparam int TOUT = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ok;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frm_addr;
    logic [4:0] frm_len;
    logic       frm_ok;
    logic [2:0] err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int n_ok = 0, n_e0 = 0, n_e1 = 0, n_e2 = 0, n_out = 0;
    logic [7:0] out_b [64];
    logic       out_l [64];

    int b_ok, b_e0, b_e1, b_e2, b_out;

    uart_frame_parser #(
        .MAX_LEN(16), .TIMEOUT_CYC(TOUT), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ok(rx_ok),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frm_addr(frm_addr), .frm_len(frm_len),
        .frm_ok(frm_ok), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulses are counted per high cycle, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (frm_ok) n_ok++;
        if (err[0]) n_e0++;
        if (err[1]) n_e1++;
        if (err[2]) n_e2++;
        if (out_valid && out_ready && n_out < 64) begin
            out_b[n_out] = out_data;
            out_l[n_out] = out_last;
            n_out++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_ok   = 1'b1;
        @(posedge clk);
        #1;
        rx_ok = 1'b0;
    endtask

    task automatic mark();
        b_ok  = n_ok;
        b_e0  = n_e0;
        b_e1  = n_e1;
        b_e2  = n_e2;
        b_out = n_out;
    endtask

    initial begin
        rst       = 1'b0;
        rx_ok     = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        wait_cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", frm_addr, 0);
        chk("rst_len", frm_len, 0);
        chk("rst_ok", frm_ok, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        wait_cyc(2);

        // Good 3-byte frame
        mark();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
        chk("a_send_busy", busy, 1);
        chk("a_send_ok", frm_ok, 1);
        wait_cyc(10);
        chk("a_ok_cnt", n_ok - b_ok, 1);
        chk("a_out_cnt", n_out - b_out, 3);
        chk("a_b0", out_b[b_out], 8'h11);
        chk("a_b1", out_b[b_out+1], 8'h22);
        chk("a_b2", out_b[b_out+2], 8'h33);
        chk("a_l0", out_l[b_out], 0);
        chk("a_l1", out_l[b_out+1], 0);
        chk("a_l2", out_l[b_out+2], 1);
        chk("a_addr", frm_addr, 8'h10);
        chk("a_len", frm_len, 3);
        chk("a_err", (n_e0 - b_e0) + (n_e1 - b_e1) + (n_e2 - b_e2), 0);
        chk("a_busy_end", busy, 0);

        // Same frame, wrong checksum
        mark();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h14);
        wait_cyc(5);
        chk("b_e0", n_e0 - b_e0, 1);
        chk("b_ok", n_ok - b_ok, 0);
        chk("b_out", n_out - b_out, 0);
        chk("b_busy", busy, 0);

        // Oversize LEN, then a frame whose payload is the sync value
        mark();
        send_byte(8'hA5); send_byte(8'h11);
        wait_cyc(2);
        chk("c_e1", n_e1 - b_e1, 1);
        chk("c_busy", busy, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h20);
        send_byte(8'hA5); send_byte(8'h84);
        wait_cyc(5);
        chk("c_ok", n_ok - b_ok, 1);
        chk("c_out", n_out - b_out, 1);
        chk("c_b0", out_b[b_out], 8'hA5);
        chk("c_l0", out_l[b_out], 1);
        chk("c_addr", frm_addr, 8'h20);
        chk("c_e0", n_e0 - b_e0, 0);

        // Inter-byte timeout
        mark();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA);
        wait_cyc(TOUT - 100);
        chk("d_busy_pre", busy, 1);
        chk("d_e2_pre", n_e2 - b_e2, 0);
        wait_cyc(200);
        chk("d_e2", n_e2 - b_e2, 1);
        chk("d_busy", busy, 0);
        chk("d_ok", n_ok - b_ok, 0);

        // Back-pressure with a byte dropped during SEND
        mark();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h30);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h23);
        wait_cyc(5);
        chk("e_valid", out_valid, 1);
        chk("e_data", out_data, 8'h44);
        chk("e_last", out_last, 0);
        send_byte(8'h99);
        wait_cyc(40);
        chk("e_e2", n_e2 - b_e2, 1);
        chk("e_valid_hold", out_valid, 1);
        chk("e_data_hold", out_data, 8'h44);
        chk("e_busy", busy, 1);
        out_ready = 1'b1;
        wait_cyc(6);
        chk("e_out", n_out - b_out, 2);
        chk("e_b0", out_b[b_out], 8'h44);
        chk("e_b1", out_b[b_out+1], 8'h55);
        chk("e_l1", out_l[b_out+1], 1);
        chk("e_busy_end", busy, 0);
        chk("e_ok", n_ok - b_ok, 1);

        // Reset in DATA with rx_ok held high across release, then a LEN=0 frame
        mark();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h40); send_byte(8'h01);
        chk("f_busy_pre", busy, 1);
        @(posedge clk);
        #1;
        rx_data = 8'hA5;
        rx_ok   = 1'b1;
        rst     = 1'b0;
        wait_cyc(1);
        chk("f_busy", busy, 0);
        chk("f_addr", frm_addr, 0);
        chk("f_len", frm_len, 0);
        chk("f_valid", out_valid, 0);
        chk("f_err", err, 0);
        rst = 1'b1;
        wait_cyc(3);
        chk("f_nostrobe", busy, 0);
        rx_ok = 1'b0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07); send_byte(8'h07);
        wait_cyc(4);
        chk("f_ok", n_ok - b_ok, 1);
        chk("f_out", n_out - b_out, 0);
        chk("f_addr2", frm_addr, 8'h07);
        chk("f_busy_end", busy, 0);
        chk("f_errs", (n_e0 - b_e0) + (n_e1 - b_e1) + (n_e2 - b_e2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
